// File: rtl/control_sequencer.sv
// Stage sequencer and control decoder for the 8-bit core: LOAD/FETCH/DECODE/DWAIT/EXECUTE FSM.
// Optional single-step mode enabled by defining CONTROL_SEQUENCER_STEP_EN.
module control_sequencer #(
  parameter int unsigned IW         = 12,
  parameter int unsigned SR_W       = 4,
  parameter int unsigned PROG_DEPTH = 16,
  parameter int unsigned WAIT_MAX   = 7,
  parameter int unsigned CNT_W      = 16,
  localparam int unsigned LA_W      = $clog2(PROG_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             run_start,
  input  logic             halt_req,
`ifdef CONTROL_SEQUENCER_STEP_EN
  input  logic             step,
`endif
  input  logic [IW-1:0]    I,
  input  logic [SR_W-1:0]  SR,
  input  logic             dmem_rdy,
  output logic             pc_e,
  output logic             acc_e,
  output logic             alu_e,
  output logic             ir_e,
  output logic             sr_e,
  output logic             dr_e,
  output logic             dmem_e,
  output logic             dmem_we,
  output logic             pmem_e,
  output logic             pmem_le,
  output logic             mux1_sel,
  output logic             mux2_sel,
  output logic [3:0]       alu_mode,
  output logic [LA_W-1:0]  load_addr,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int unsigned WC_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_FETCH   = 3'd2,
    S_DECODE  = 3'd3,
    S_DWAIT   = 3'd4,
    S_EXECUTE = 3'd5
`ifdef CONTROL_SEQUENCER_STEP_EN
    , S_STEP  = 3'd6
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [LA_W-1:0]  load_cnt_q, load_cnt_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic             err_q, err_d;

  logic       is_mem;
  logic [1:0] idx;
  logic [3:0] sr_ext;

  assign is_mem = (I[IW-1:IW-3] == 3'b001);
  assign idx    = I[IW-3:IW-4];

  // Flags beyond SR_W read as 0 so the jump condition index never leaves SR.
  for (genvar g = 0; g < 4; g++) begin : g_sr_ext
    if (g < SR_W) begin : g_in
      assign sr_ext[g] = SR[g];
    end else begin : g_out
      assign sr_ext[g] = 1'b0;
    end
  end

  if (SR_W > 4) begin : g_sr_unused
    logic unused_sr;
    assign unused_sr = ^SR[SR_W-1:4];
  end
  if (IW > 8) begin : g_i_unused
    logic unused_i;
    assign unused_i = ^I[IW-9:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      load_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      instr_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      instr_cnt_q <= instr_cnt_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    instr_cnt_d = instr_cnt_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d    = S_LOAD;
          load_cnt_d = '0;
          err_d      = 1'b0;
        end else if (run_start) begin
          state_d = S_FETCH;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        load_cnt_d = load_cnt_q + LA_W'(1);
        if (load_cnt_q == LA_W'(PROG_DEPTH - 1)) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (is_mem && !dmem_rdy) begin
          state_d    = S_DWAIT;
          wait_cnt_d = '0;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_DWAIT: begin
        if (dmem_rdy) begin
          state_d = S_EXECUTE;
        end else if (wait_cnt_q == WC_W'(WAIT_MAX - 1)) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      S_EXECUTE: begin
        if (instr_cnt_q != '1) instr_cnt_d = instr_cnt_q + CNT_W'(1);
`ifdef CONTROL_SEQUENCER_STEP_EN
        state_d = halt_req ? S_IDLE : S_STEP;
`else
        state_d = halt_req ? S_IDLE : S_FETCH;
`endif
      end
`ifdef CONTROL_SEQUENCER_STEP_EN
      S_STEP: begin
        if (halt_req)  state_d = S_IDLE;
        else if (step) state_d = S_FETCH;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_e      = 1'b0;
    acc_e     = 1'b0;
    alu_e     = 1'b0;
    ir_e      = 1'b0;
    sr_e      = 1'b0;
    dr_e      = 1'b0;
    dmem_e    = 1'b0;
    dmem_we   = 1'b0;
    pmem_e    = 1'b0;
    pmem_le   = 1'b0;
    mux1_sel  = 1'b0;
    mux2_sel  = 1'b0;
    alu_mode  = 4'h0;
    load_addr = '0;
    case (state_q)
      S_LOAD: begin
        pmem_e    = 1'b1;
        pmem_le   = 1'b1;
        load_addr = load_cnt_q;
      end
      S_FETCH: begin
        pmem_e = 1'b1;
        ir_e   = 1'b1;
      end
      S_DECODE: begin
        dmem_e = is_mem;
        dr_e   = is_mem;
      end
      S_DWAIT: begin
        dmem_e = 1'b1;
        dr_e   = 1'b1;
      end
      S_EXECUTE: begin
        pc_e = 1'b1;
        if (I[IW-1]) begin
          acc_e    = 1'b1;
          alu_e    = 1'b1;
          sr_e     = 1'b1;
          alu_mode = {1'b0, I[IW-2:IW-4]};
          mux1_sel = 1'b1;
        end else if (I[IW-2]) begin
          mux1_sel = sr_ext[idx];
        end else if (I[IW-3]) begin
          alu_e    = 1'b1;
          sr_e     = 1'b1;
          dmem_e   = 1'b1;
          acc_e    = I[IW-4];
          dmem_we  = ~I[IW-4];
          alu_mode = I[IW-5:IW-8];
          mux1_sel = 1'b1;
          mux2_sel = 1'b1;
        end else if (I[IW-4]) begin
          mux1_sel = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;
  assign instr_cnt = instr_cnt_q;

endmodule
